// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state encoding, reset pattern and saturating-increment helper.
package seq_detect_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, IRQ} state_t;

    localparam logic [3:0] DEFAULT_PAT = 4'b1001;

    // Callers cast the result back to their own counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max;
        max = (32'd1 << w) - 32'd1;
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_if.sv
// seq_detect_if: serial input, config handshake, control and status signals of the detector.
interface seq_detect_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_threshold;
    logic             start;
    logic             stop;
    logic             d;
    logic [CNT_W-1:0] hit_count;
    logic             irq;
    logic             irq_ack;
    logic             busy;

    modport master (
        output in, cfg_valid, cfg_pattern, cfg_overlap, cfg_threshold, start, stop, irq_ack,
        input  cfg_ready, d, hit_count, irq, busy
    );

    modport slave (
        input  in, cfg_valid, cfg_pattern, cfg_overlap, cfg_threshold, start, stop, irq_ack,
        output cfg_ready, d, hit_count, irq, busy
    );
endinterface

// File: rtl/seq_match_shift.sv
// seq_match_shift: serial shift register with fill count; flags a match on the bit being shifted in.
module seq_match_shift #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift_en,
    input  logic             i_clear,
    input  logic             i_overlap,
    input  logic             i_in,
    input  logic [PAT_W-1:0] i_pattern,
    output logic             o_match_next
);
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] r_sh;
    logic [PAT_W-1:0] w_sh_next;
    logic [FW-1:0]    r_fill;
    logic [FW-1:0]    w_fill_next;

    assign w_sh_next    = {r_sh[PAT_W-2:0], i_in};
    assign w_fill_next  = (r_fill == FW'(PAT_W)) ? r_fill : r_fill + 1'b1;
    assign o_match_next = i_shift_en && (w_fill_next == FW'(PAT_W)) && (w_sh_next == i_pattern);

    // Non-overlapping mode restarts the fill so the matched bits cannot be reused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh   <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_sh   <= '0;
            r_fill <= '0;
        end else if (i_shift_en) begin
            r_sh   <= w_sh_next;
            r_fill <= (o_match_next && !i_overlap) ? '0 : w_fill_next;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable pattern detector with config handshake, hit counter and threshold irq.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PAT)
) (
    input  logic        clk,
    input  logic        rst,
    seq_detect_if.slave bus
);
    state_t           r_state;
    logic [PAT_W-1:0] r_pat;
    logic             r_ovl;
    logic [CNT_W-1:0] r_thr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_inc;
    logic             r_d;
    logic             r_irq;
    logic             r_busy;
    logic             r_rdy;
    logic             w_match;
    logic             w_shift_en;
    logic             w_clear;

    // stop wins over both a pending match and irq_ack.
    assign w_shift_en = (r_state == ARMED) && !bus.stop;
    assign w_clear    = ((r_state == IDLE) && bus.start) || ((r_state == IRQ) && bus.irq_ack && !bus.stop);
    assign w_inc      = CNT_W'(sat_inc(32'(r_cnt), CNT_W));

    seq_match_shift #(.PAT_W(PAT_W)) u_shift (
        .clk          (clk),
        .rst          (rst),
        .i_shift_en   (w_shift_en),
        .i_clear      (w_clear),
        .i_overlap    (r_ovl),
        .i_in         (bus.in),
        .i_pattern    (r_pat),
        .o_match_next (w_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pat   <= RST_PAT;
            r_ovl   <= 1'b1;
            r_thr   <= '0;
            r_cnt   <= '0;
            r_d     <= 1'b0;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
        end else begin
            r_d <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        r_pat <= bus.cfg_pattern;
                        r_ovl <= bus.cfg_overlap;
                        r_thr <= bus.cfg_threshold;
                    end
                    if (bus.start) begin
                        r_state <= ARMED;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_rdy   <= 1'b0;
                    end
                end
                ARMED: begin
                    if (bus.stop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                    end else if (w_match) begin
                        r_d   <= 1'b1;
                        r_cnt <= w_inc;
                        if (r_thr != '0 && w_inc == r_thr) begin
                            r_state <= IRQ;
                            r_irq   <= 1'b1;
                        end
                    end
                end
                IRQ: begin
                    if (bus.stop) begin
                        r_state <= IDLE;
                        r_irq   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                    end else if (bus.irq_ack) begin
                        r_state <= ARMED;
                        r_irq   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.d         = r_d;
    assign bus.hit_count = r_cnt;
    assign bus.irq       = r_irq;
    assign bus.busy      = r_busy;
    assign bus.cfg_ready = r_rdy;
endmodule
